mux_rr_arbiter: RTL
===================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one W-bit N:1 mux among N requesters.
//  Grants one requester at a time, drives the mux select and forwards the
//  winner's data to a single output with a valid flag.
//  Sits in front of any shared single-consumer path built from the 2:1 mux
//  primitives, and replaces hand-driven sel signals.
// PARAMETERS
//  N         4   number of requesters (N >= 2)
//  W         8   data width per requester
//  MAX_HOLD  8   max consecutive grant cycles; used only with ARB_TIMEOUT_EN (>= 1)
// PORTS
//  clk       in   1               single clock, rising edge
//  rst       in   1               synchronous, active-high reset
//  req       in   N               request per requester, level-sensitive
//  data_in   in   N*W             requester i data at data_in[i*W +: W]
//  grant     out  N               one-hot grant, registered
//  sel       out  clog2(N)        index of granted requester, registered
//  data_out  out  W               data_in slice selected by sel; 0 when !valid
//  valid     out  1               1 while a grant is held (== |grant)
// BEHAVIOUR
//  - Reset: grant=0, sel=0, valid=0, data_out=0, ptr=0, hold_cnt=0.
//    A reset in mid-grant drops grant at that same edge. No partial state survives.
//  - ptr: the round-robin start index. After every new grant to index k,
//    ptr = (k+1) mod N, wrapping N-1 -> 0.
//  - Winner: the first i with req[i]=1, scanning ptr, ptr+1, ... mod N.
//  - FSM, two states:
//    IDLE: grant=0. If |req, the next edge grants the winner and goes to BUSY.
//      Otherwise stay in IDLE.
//    BUSY: hold grant while req[sel]=1.
//      If req[sel]=0 and another req is set, the next edge grants the new
//      winner back-to-back, with no idle cycle. The released index is
//      excluded from the scan.
//      If req[sel]=0 and no other req is set, the next edge goes to IDLE.
//  - Latency: request to grant takes 1 cycle. Release to regrant takes 1 cycle.
//  - data_out: combinational mux of data_in on registered sel, gated by valid.
//    It follows data_in changes within the cycle.
//  - Simultaneous requests are resolved only by ptr order. There is no
//    fixed priority.
//  - A requester that drops and re-raises req loses its slot. It is
//    re-arbitrated by ptr.
//  - An outstanding grant is never revoked because another requester
//    arrives. Revocation happens only by release or timeout.
//  - hold_cnt: clog2(MAX_HOLD+1) bits.
//    Cleared on every new grant and in IDLE.
//    Incremented each BUSY cycle, saturating at MAX_HOLD.
// CONFIGURATION
//  `define ARB_TIMEOUT_EN
//  - Defined:
//    In BUSY, when hold_cnt == MAX_HOLD-1 and another req is set, the next
//    edge forces rotation to the next winner, even if req[sel]=1.
//    If no other req is set, the grant is kept and hold_cnt saturates.
//  - Undefined:
//    hold_cnt and its logic are not compiled. A grant is held until req[sel]
//    falls. MAX_HOLD is ignored.
// TESTING
//  1. Reset: rst=1 for 2 cycles with req=4'b1111.
//     -> grant=0, sel=0, valid=0, data_out=0.
//     Release rst -> next edge grant=4'b0001.
//  2. Single request: req=4'b0100, data_in[2]=8'hA5 at cycle 0.
//     -> cycle 1: grant=4'b0100, sel=2, valid=1, data_out=8'hA5.
//     Drop req -> next edge valid=0.
//  3. Rotation: req=4'b1111; each grantee drops req 1 cycle after its grant,
//     then re-raises it.
//     -> grant order 0,1,2,3,0 back-to-back, valid never falls.
//  4. Wrap and no-idle release: last winner 3 (ptr=0), req=4'b1010.
//     -> grant=4'b0010.
//     Release 1 while req[3]=1 -> next edge grant=4'b1000.
//  5. Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4), req=4'b0011 held.
//     -> grant=0001 for 4 cycles, 0010 for 4 cycles, then 0001 again.
//     Same stimulus without the macro -> grant=0001 indefinitely.
//  6. Reset mid-grant: BUSY with grant=4'b0100, assert rst for 1 cycle.
//     -> grant=0 at that edge, ptr=0.
//     With req=4'b0101 after reset -> grant=4'b0001.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// mux_rr_arbiter_if
// Bundle of the requester-side and consumer-side signals of the round-robin
// mux arbiter.
//
// Signals:
//   req       N        level-sensitive request, one bit per requester
//   data_in   N*W      requester i data at data_in[i*W +: W]
//   grant     N        one-hot grant (registered)
//   sel       clog2(N) index of the granted requester (registered)
//   data_out  W        selected data, zero while no grant is held
//   valid     1        high while a grant is held
//
// Modports:
//   master    requester/consumer side (drives req, data_in)
//   slave     arbiter side (drives grant, sel, data_out, valid)
// ----------------------------------------------------------------------------
interface mux_rr_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   grant;
    logic [SW-1:0]  sel;
    logic [W-1:0]   data_out;
    logic           valid;

    modport master (
        output req, data_in,
        input  grant, sel, data_out, valid
    );

    modport slave (
        input  req, data_in,
        output grant, sel, data_out, valid
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter sharing one W-bit N:1 mux among N requesters. One
// requester is granted at a time; the mux select is driven from the
// registered grant index and the winner's data is forwarded with a valid flag.
//
// Ports:
//   clk   in  single clock, rising edge
//   rst   in  synchronous, active-high reset
//   bus   slave modport of mux_rr_arbiter_if (req, data_in in;
//         grant, sel, data_out, valid out)
//
// Parameters:
//   N         number of requesters (>= 2)
//   W         data width per requester
//   MAX_HOLD  max consecutive grant cycles (only with ARB_TIMEOUT_EN)
//
// Configuration macro:
//   ARB_TIMEOUT_EN  when defined, a grant held for MAX_HOLD cycles is
//                   rotated away if another requester is waiting. When
//                   undefined, a grant is held until its request falls.
// ----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.slave   bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [SW-1:0] sel_q,   sel_d;
    logic [SW-1:0] ptr_q,   ptr_d;

    logic [N-1:0]  cand;
    logic [SW:0]   pick;
    logic          win_found;
    logic [SW-1:0] win;
    logic          new_grant;
    logic          timeout;

    // First set bit of r, scanning start, start+1, ... modulo N.
    // Returns {found, index}.
    function automatic logic [SW:0] rr_pick(input logic [N-1:0] r,
                                            input logic [SW-1:0] start);
        logic          found;
        logic [SW-1:0] idx;
        int            pos;
        found = 1'b0;
        idx   = start;
        for (int off = 0; off < N; off++) begin
            pos = (int'(start) + off) % N;
            if (!found && r[pos]) begin
                found = 1'b1;
                idx   = SW'(pos);
            end
        end
        return {found, idx};
    endfunction

    // The current grantee is masked out of the scan: after a release its req
    // is already low, and on a timeout it must lose even though req is high.
    // In IDLE grant_q is zero so this is simply req.
    assign cand      = bus.req & ~grant_q;
    assign pick      = rr_pick(cand, ptr_q);
    assign win_found = pick[SW];
    assign win       = pick[SW-1:0];

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    // Fires on the last allowed cycle so the rotation lands after exactly
    // MAX_HOLD granted cycles.
    assign timeout = (state_q == BUSY) && (hold_cnt_q == HW'(MAX_HOLD - 1));
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;

        if (state_q == IDLE) begin
            new_grant = win_found;
        end else begin
            if (!bus.req[sel_q] || timeout) begin
                if (win_found) begin
                    new_grant = 1'b1;
                end else if (!bus.req[sel_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
                // Timeout with nobody else waiting: keep the grant.
            end
        end

        if (new_grant) begin
            state_d = BUSY;
            grant_d = N'(1) << win;
            sel_d   = win;
            ptr_d   = (win == SW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (new_grant || state_d == IDLE) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HW'(MAX_HOLD)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    assign bus.grant    = grant_q;
    assign bus.sel      = sel_q;
    assign bus.valid    = |grant_q;
    // Combinational on the registered select so data_in changes pass through
    // within the same cycle.
    assign bus.data_out = (|grant_q) ? bus.data_in[sel_q*W +: W] : '0;

endmodule
